// File: rtl/ls374_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ls374_pkg
// Description : Shared constants and helpers for the ls374_fifo block.
//               DEF_WIDTH / DEF_DEPTH : default data width and FIFO depth.
//               clog2()               : ceiling log2, used to size the
//                                       pointers and the occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
package ls374_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  // Smallest r such that 2**r >= value (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

endpackage : ls374_pkg
`default_nettype wire

// File: rtl/ls374_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ls374_fifo_ctrl
// Description : Pointer, occupancy and status control for ls374_fifo.
//               Decides which requests are accepted on each edge and keeps
//               the sticky overflow / underflow flags.
// Ports       : clk, rst_n          clock, synchronous active-low reset
//               i_wr_en, i_rd_en    write / read requests
//               i_clr               synchronous flush
//               o_wr_acc, o_rd_acc  accepted write / read this edge
//               o_wr_ptr, o_rd_ptr  tail / head storage index
//               o_count             stored word count
//               o_full, o_empty     decodes of o_count
//               o_ovf, o_unf        sticky overflow / underflow
// Revision    : 1.0 - initial release
// ============================================================================
module ls374_fifo_ctrl
  import ls374_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PW   = clog2(DEPTH),
  localparam int unsigned CW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  input  logic          i_clr,
  output logic          o_wr_acc,
  output logic          o_rd_acc,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ovf,
  output logic          o_unf
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A read frees a slot on the same edge, so a full FIFO still takes a
  // write when a read is accepted alongside it.
  assign w_rd_acc = i_rd_en & ~w_empty;
  assign w_wr_acc = i_wr_en & (~w_full | w_rd_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + {{(CW-1){1'b0}}, w_wr_acc}
                         - {{(CW-1){1'b0}}, w_rd_acc};
      if (i_wr_en && !w_wr_acc) begin
        r_ovf <= 1'b1;
      end
      if (i_rd_en && w_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Storage and output register only see accepts that actually take effect.
  assign o_wr_acc = w_wr_acc & rst_n & ~i_clr;
  assign o_rd_acc = w_rd_acc & rst_n & ~i_clr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_ovf    = r_ovf;
  assign o_unf    = r_unf;

endmodule : ls374_fifo_ctrl
`default_nettype wire

// File: rtl/ls374_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ls374_fifo
// Description : Synchronous FIFO whose head word is popped into a
//               74LS374-style output register with active-low tri-state
//               output enable. No first-word fall-through.
// Ports       : clk, rst_n   clock, synchronous active-low reset
//               d_in, wr_en  write data / write request
//               rd_en        read request (pops head into output register)
//               clr          synchronous flush (output register kept)
//               oe_n         active-low output enable (combinational)
//               d_out        output register, high-Z when oe_n = 1
//               full, empty  occupancy decodes
//               count        stored word count
//               ovf, unf     sticky overflow / underflow
// Revision    : 1.0 - initial release
// ============================================================================
module ls374_fifo
  import ls374_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PW   = clog2(DEPTH),
  localparam int unsigned CW   = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr,
  input  logic             oe_n,
  output wire logic [WIDTH-1:0] d_out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;

  ls374_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (wr_en),
    .i_rd_en  (rd_en),
    .i_clr    (clr),
    .o_wr_acc (w_wr_acc),
    .o_rd_acc (w_rd_acc),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (count),
    .o_full   (full),
    .o_empty  (empty),
    .o_ovf    (ovf),
    .o_unf    (unf)
  );

  // Storage is intentionally not reset. On a full write+read the pointers
  // coincide; the read below sees the old word because both are registered.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_ptr] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (w_rd_acc) begin
      r_q <= r_mem[w_rd_ptr];
    end
  end

  assign d_out = oe_n ? {WIDTH{1'bz}} : r_q;

endmodule : ls374_fifo
`default_nettype wire
